// File: rtl/pipeline_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_flush_ctrl
//  Purpose  : Flush/redirect controller for the 5-stage RISC-V pipeline.
//             Converts taken-branch and trap events into a registered
//             per-stage flush mask, a fetch PC redirect and a fetch-hold
//             window covering i-mem refill. Counts accepted flush events.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_flush_ctrl #(
  parameter int XLEN            = 32,
  parameter int NUM_STAGES      = 5,
  parameter int BR_FLUSH_STAGES = 2,
  parameter int REFILL_CYCLES   = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_taken_i,
  input  logic [XLEN-1:0]       branch_target_i,
  input  logic                  trap_i,
  input  logic [XLEN-1:0]       trap_vector_i,
  input  logic                  stall_i,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_valid_o,
  output logic [XLEN-1:0]       redirect_pc_o,
  output logic                  fetch_hold_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  // Refill down-counter sized for REFILL_CYCLES; loaded with N-1 so that
  // REFILL lasts exactly N cycles.
  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam int RC_LOAD_INT = (REFILL_CYCLES > 0) ? (REFILL_CYCLES - 1) : 0;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RC_LOAD_INT);

  // Branch squashes the youngest BR_FLUSH_STAGES stages (IF upward).
  localparam logic [NUM_STAGES-1:0] BR_MASK =
    {NUM_STAGES{1'b1}} >> (NUM_STAGES - BR_FLUSH_STAGES);
  localparam logic [NUM_STAGES-1:0] TRAP_MASK = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] IF_MASK   = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t                state_q;
  logic [NUM_STAGES-1:0] flush_q;
  logic                  redirect_valid_q;
  logic [XLEN-1:0]       redirect_pc_q;
  logic                  fetch_hold_q;
  logic                  busy_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [RC_W-1:0]       refill_q;

  // Saturating increment of the event counter, used whenever an event is accepted.
  always_comb begin
    count_d = count_q;
    if (count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Controller FSM with registered outputs; a trap pre-empts everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      flush_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fetch_hold_q     <= 1'b0;
      busy_q           <= 1'b0;
      count_q          <= '0;
      refill_q         <= '0;
    end else if (trap_i) begin
      state_q          <= S_FLUSH;
      flush_q          <= TRAP_MASK;
      redirect_valid_q <= 1'b1;
      redirect_pc_q    <= trap_vector_i;
      fetch_hold_q     <= 1'b0;
      busy_q           <= 1'b1;
      count_q          <= count_d;
      refill_q         <= RC_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Branches are only trusted here; in other states they are wrong-path.
          if (branch_taken_i) begin
            state_q          <= S_FLUSH;
            flush_q          <= BR_MASK;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= branch_target_i;
            fetch_hold_q     <= 1'b0;
            busy_q           <= 1'b1;
            count_q          <= count_d;
            refill_q         <= RC_LOAD;
          end
        end
        S_FLUSH: begin
          // Outputs are held while stalled so the bubble lands in every stage.
          if (!stall_i) begin
            if (REFILL_CYCLES > 0) begin
              state_q          <= S_REFILL;
              flush_q          <= IF_MASK;
              redirect_valid_q <= 1'b0;
              fetch_hold_q     <= 1'b1;
              busy_q           <= 1'b1;
              refill_q         <= RC_LOAD;
            end else begin
              state_q          <= S_IDLE;
              flush_q          <= '0;
              redirect_valid_q <= 1'b0;
              fetch_hold_q     <= 1'b0;
              busy_q           <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          // Refill timing tracks the i-mem, not the pipeline, so stall is ignored.
          if (refill_q == '0) begin
            state_q          <= S_IDLE;
            flush_q          <= '0;
            redirect_valid_q <= 1'b0;
            fetch_hold_q     <= 1'b0;
            busy_q           <= 1'b0;
          end else begin
            refill_q <= refill_q - RC_W'(1);
          end
        end
        default: begin
          state_q          <= S_IDLE;
          flush_q          <= '0;
          redirect_valid_q <= 1'b0;
          fetch_hold_q     <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign fetch_hold_o     = fetch_hold_q;
  assign busy_o           = busy_q;
  assign flush_count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_flush_ctrl
//  Purpose  : Directed self-checking bench for pipeline_flush_ctrl. Two
//             instances share stimulus: default parameters, and a variant
//             with CNT_W=2 / REFILL_CYCLES=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_flush_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        trap_i;
  logic [31:0] trap_vector_i;
  logic        stall_i;

  logic [4:0]  flush_a;
  logic        rv_a;
  logic [31:0] pc_a;
  logic        hold_a;
  logic        busy_a;
  logic [15:0] cnt_a;

  logic [4:0]  flush_b;
  logic        rv_b;
  logic [31:0] pc_b;
  logic        hold_b;
  logic        busy_b;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  pipeline_flush_ctrl u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_vector_i   (trap_vector_i),
    .stall_i         (stall_i),
    .flush_o         (flush_a),
    .redirect_valid_o(rv_a),
    .redirect_pc_o   (pc_a),
    .fetch_hold_o    (hold_a),
    .busy_o          (busy_a),
    .flush_count_o   (cnt_a)
  );

  pipeline_flush_ctrl #(
    .CNT_W        (2),
    .REFILL_CYCLES(0)
  ) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_vector_i   (trap_vector_i),
    .stall_i         (stall_i),
    .flush_o         (flush_b),
    .redirect_valid_o(rv_b),
    .redirect_pc_o   (pc_b),
    .fetch_hold_o    (hold_b),
    .busy_o          (busy_b),
    .flush_count_o   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] f, input logic rv,
                       input logic [31:0] pc, input logic h, input logic b,
                       input logic [15:0] c);
    chk({tag, ".a.flush"}, 64'(flush_a), 64'(f));
    chk({tag, ".a.rv"},    64'(rv_a),    64'(rv));
    chk({tag, ".a.pc"},    64'(pc_a),    64'(pc));
    chk({tag, ".a.hold"},  64'(hold_a),  64'(h));
    chk({tag, ".a.busy"},  64'(busy_a),  64'(b));
    chk({tag, ".a.cnt"},   64'(cnt_a),   64'(c));
  endtask

  task automatic chk_b(input string tag, input logic [4:0] f, input logic rv,
                       input logic h, input logic b, input logic [1:0] c);
    chk({tag, ".b.flush"}, 64'(flush_b), 64'(f));
    chk({tag, ".b.rv"},    64'(rv_b),    64'(rv));
    chk({tag, ".b.hold"},  64'(hold_b),  64'(h));
    chk({tag, ".b.busy"},  64'(busy_b),  64'(b));
    chk({tag, ".b.cnt"},   64'(cnt_b),   64'(c));
  endtask

  // Advance one rising edge and settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    trap_i          = 1'b0;
    trap_vector_i   = '0;
    stall_i         = 1'b0;
    #12;
    chk_a("reset", 5'b00000, 0, 32'h0, 0, 0, 16'd0);
    chk_b("reset", 5'b00000, 0, 0, 0, 2'd0);
    chk("reset.b.pc", 64'(pc_b), 64'h0);
    rst_n = 1'b1;
    step();
    chk_a("idle", 5'b00000, 0, 32'h0, 0, 0, 16'd0);

    // 1: branch in IDLE
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0100;
    step();
    branch_taken_i = 1'b0; branch_target_i = 32'hDEAD_BEEF;
    chk_a("br.flush", 5'b00011, 1, 32'h100, 0, 1, 16'd1);
    chk_b("br.flush", 5'b00011, 1, 0, 1, 2'd1);
    chk("br.b.pc", 64'(pc_b), 64'h100);
    step();
    chk_a("br.refill", 5'b00001, 0, 32'h100, 1, 1, 16'd1);
    chk_b("br.noref", 5'b00000, 0, 0, 0, 2'd1);
    step();
    chk_a("br.idle", 5'b00000, 0, 32'h100, 0, 0, 16'd1);

    // 2: trap and branch together, trap wins
    trap_i = 1'b1; trap_vector_i = 32'h8000_0000;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0200;
    step();
    trap_i = 1'b0; branch_taken_i = 1'b0;
    chk_a("trbr.flush", 5'b11111, 1, 32'h8000_0000, 0, 1, 16'd2);
    chk_b("trbr.flush", 5'b11111, 1, 0, 1, 2'd2);
    step();
    chk_a("trbr.refill", 5'b00001, 0, 32'h8000_0000, 1, 1, 16'd2);
    step();
    chk_a("trbr.idle", 5'b00000, 0, 32'h8000_0000, 0, 0, 16'd2);

    // 3: branch then 3 stall cycles
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0300;
    step();
    branch_taken_i = 1'b0;
    chk_a("st.flush0", 5'b00011, 1, 32'h300, 0, 1, 16'd3);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("st.held", 5'b00011, 1, 32'h300, 0, 1, 16'd3);
      chk_b("st.held", 5'b00011, 1, 0, 1, 2'd3);
    end
    stall_i = 1'b0;
    step();
    chk_a("st.refill", 5'b00001, 0, 32'h300, 1, 1, 16'd3);
    chk_b("st.idle", 5'b00000, 0, 0, 0, 2'd3);
    step();
    chk_a("st.idle", 5'b00000, 0, 32'h300, 0, 0, 16'd3);

    // 4: branch, trap during REFILL, branch during FLUSH ignored
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0400;
    step();
    branch_taken_i = 1'b0;
    chk_a("tr.flush", 5'b00011, 1, 32'h400, 0, 1, 16'd4);
    chk_b("sat.br", 5'b00011, 1, 0, 1, 2'd3);
    step();
    chk_a("tr.refill", 5'b00001, 0, 32'h400, 1, 1, 16'd4);
    trap_i = 1'b1; trap_vector_i = 32'h0000_1000;
    step();
    trap_i = 1'b0;
    chk_a("tr.reflush", 5'b11111, 1, 32'h1000, 0, 1, 16'd5);
    chk_b("sat.tr", 5'b11111, 1, 0, 1, 2'd3);
    chk("tr.b.pc", 64'(pc_b), 64'h1000);
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h0000_0500;
    step();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    chk_a("tr.brign", 5'b11111, 1, 32'h1000, 0, 1, 16'd5);
    chk_b("tr.brign", 5'b11111, 1, 0, 1, 2'd3);
    step();
    chk_a("tr.refill2", 5'b00001, 0, 32'h1000, 1, 1, 16'd5);
    step();
    chk_a("tr.idle", 5'b00000, 0, 32'h1000, 0, 0, 16'd5);

    // 6: async reset in FLUSH
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0600;
    step();
    branch_taken_i = 1'b0;
    chk_a("rst.pre", 5'b00011, 1, 32'h600, 0, 1, 16'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("rst.async", 5'b00000, 0, 32'h0, 0, 0, 16'd0);
    chk_b("rst.async", 5'b00000, 0, 0, 0, 2'd0);
    rst_n = 1'b1;
    step();
    chk_a("rst.idle", 5'b00000, 0, 32'h0, 0, 0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
